fft16_input_framer: RTL and testbench

- Upstream stage of the 16-point parallel FFT.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake and assembles them into 16-sample frames in ping-pong buffers.
- Presents each frame on the FFT's parallel X0..X15 Real/Im inputs and holds it stable for the FFT's pipeline latency.
- Lets streaming continue while the FFT consumes the previous frame.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft16_input_framer_if.sv | 27 ++
 rtl/fft_frame_bank.sv | 32 +++
 rtl/fft16_input_framer.sv | 168 ++++++++++++++++
 tb/tb_fft16_input_framer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point FFT input framer.
package fft_pkg;

   localparam int DATA_W = 16;
   localparam int N      = 16;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic [2:0] {
      BANK_EMPTY   = 3'd0,
      BANK_FILLING = 3'd1,
      BANK_FULL    = 3'd2,
      BANK_PRESENT = 3'd3,
      BANK_HOLD    = 3'd4
   } bank_state_t;

   typedef enum logic [1:0] {
      RD_IDLE    = 2'd0,
      RD_PRESENT = 2'd1,
      RD_HOLD    = 2'd2
   } rd_state_t;

   // A bank may take samples only while nobody downstream owns it.
   function automatic logic bank_writable(input bank_state_t st);
      return (st == BANK_EMPTY) || (st == BANK_FILLING);
   endfunction

endpackage

// File: rtl/fft16_input_framer_if.sv
// Sample stream in, parallel frame out: the full handshake bundle of the framer.
interface fft16_input_framer_if;
   import fft_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [DATA_W-1:0]   s_real;
   logic [DATA_W-1:0]   s_imag;
   logic                s_last;
   logic [N*DATA_W-1:0] frame_real;
   logic [N*DATA_W-1:0] frame_imag;
   logic                frame_valid;
   logic                frame_ready;
   logic                frame_busy;
   logic                frame_err;

   modport master (
      output s_valid, s_real, s_imag, s_last, frame_ready,
      input  s_ready, frame_real, frame_imag, frame_valid, frame_busy, frame_err
   );

   modport slave (
      input  s_valid, s_real, s_imag, s_last, frame_ready,
      output s_ready, frame_real, frame_imag, frame_valid, frame_busy, frame_err
   );

endinterface

// File: rtl/fft_frame_bank.sv
// One N-entry complex sample bank: indexed single-sample write, flat parallel read.
module fft_frame_bank
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_we,
   input  logic [3:0]          i_idx,
   input  cplx_t               i_data,
   output logic [N*DATA_W-1:0] o_real,
   output logic [N*DATA_W-1:0] o_imag
);

   cplx_t r_mem [N];

   // sample storage, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            r_mem[k] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_idx] <= i_data;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_flat
      assign o_real[k*DATA_W +: DATA_W] = r_mem[k].re;
      assign o_imag[k*DATA_W +: DATA_W] = r_mem[k].im;
   end

endmodule

// File: rtl/fft16_input_framer.sv
// Packs a serial complex stream into ping-pong frame banks and presents each frame
// to the parallel FFT, holding it stable through the FFT pipeline latency.
module fft16_input_framer
   import fft_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   fft16_input_framer_if.slave bus
);

   localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);
   localparam logic [3:0] IDX_LAST  = 4'(N - 1);

   bank_state_t         r_bank_st  [2];
   bank_state_t         w_bank_wr  [2];
   bank_state_t         w_bank_nxt [2];
   rd_state_t           r_rd_st;
   rd_state_t           w_rd_nxt;
   logic [3:0]          r_widx, w_widx_nxt, r_hold, w_hold_nxt;
   logic                r_wb, w_wb_nxt, r_rb, w_rb_nxt;
   logic                r_s_ready, r_frame_valid, r_frame_busy, r_frame_err;
   logic                w_accept, w_err, w_release;
   logic                w_s_ready_nxt, w_valid_nxt, w_busy_nxt;
   logic [1:0]          w_we;
   cplx_t               w_sample;
   logic [N*DATA_W-1:0] w_real [2];
   logic [N*DATA_W-1:0] w_imag [2];

   assign w_accept = bus.s_valid & r_s_ready;
   assign w_we     = {w_accept & r_wb, w_accept & ~r_wb};
   assign w_sample = '{re: bus.s_real, im: bus.s_imag};

   for (genvar g = 0; g < 2; g++) begin : g_bank
      fft_frame_bank u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_we   (w_we[g]),
         .i_idx  (r_widx),
         .i_data (w_sample),
         .o_real (w_real[g]),
         .o_imag (w_imag[g])
      );
   end

   // write side: fill bank wb, complete it at index 15, discard on an early s_last
   always_comb begin
      w_bank_wr  = r_bank_st;
      w_widx_nxt = r_widx;
      w_wb_nxt   = r_wb;
      w_err      = 1'b0;
      if (w_accept) begin
         if (r_widx == IDX_LAST) begin
            w_bank_wr[r_wb] = BANK_FULL;
            w_wb_nxt        = ~r_wb;
            w_widx_nxt      = 4'd0;
            w_err           = ~bus.s_last;
         end else if (bus.s_last) begin
            w_bank_wr[r_wb] = BANK_EMPTY;
            w_widx_nxt      = 4'd0;
            w_err           = 1'b1;
         end else begin
            w_bank_wr[r_wb] = BANK_FILLING;
            w_widx_nxt      = r_widx + 4'd1;
         end
      end else begin
         w_err = 1'b0;
      end
   end

   // read FSM next state; only touches banks that are FULL, PRESENT or HOLD
   always_comb begin
      w_bank_nxt = w_bank_wr;
      w_rd_nxt   = r_rd_st;
      w_hold_nxt = r_hold;
      w_rb_nxt   = r_rb;
      w_release  = 1'b0;
      case (r_rd_st)
         RD_IDLE: begin
            if (r_bank_st[r_rb] == BANK_FULL) begin
               w_rd_nxt         = RD_PRESENT;
               w_bank_nxt[r_rb] = BANK_PRESENT;
            end else begin
               w_rd_nxt = RD_IDLE;
            end
         end
         RD_PRESENT: begin
            if (!bus.frame_ready) begin
               w_rd_nxt = RD_PRESENT;
            end else if (HOLD_CYCLES == 0) begin
               w_release = 1'b1;
            end else begin
               w_rd_nxt         = RD_HOLD;
               w_hold_nxt       = HOLD_INIT;
               w_bank_nxt[r_rb] = BANK_HOLD;
            end
         end
         RD_HOLD: begin
            w_hold_nxt = r_hold - 4'd1;
            if (r_hold <= 4'd1) begin
               w_release = 1'b1;
            end else begin
               w_rd_nxt = RD_HOLD;
            end
         end
         default: begin
            w_rd_nxt = RD_IDLE;
         end
      endcase
      // a waiting full bank is presented directly, without an IDLE bubble
      if (w_release) begin
         w_bank_nxt[r_rb] = BANK_EMPTY;
         w_rb_nxt         = ~r_rb;
         if (r_bank_st[~r_rb] == BANK_FULL) begin
            w_rd_nxt          = RD_PRESENT;
            w_bank_nxt[~r_rb] = BANK_PRESENT;
         end else begin
            w_rd_nxt = RD_IDLE;
         end
      end else begin
         w_rb_nxt = r_rb;
      end
   end

   // next values of the registered status outputs
   always_comb begin
      w_valid_nxt   = (w_rd_nxt == RD_PRESENT);
      w_busy_nxt    = (w_rd_nxt == RD_HOLD);
      w_s_ready_nxt = bank_writable(w_bank_nxt[w_wb_nxt]);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bank_st[0]  <= BANK_EMPTY;
         r_bank_st[1]  <= BANK_EMPTY;
         r_rd_st       <= RD_IDLE;
         r_widx        <= 4'd0;
         r_hold        <= 4'd0;
         r_wb          <= 1'b0;
         r_rb          <= 1'b0;
         r_s_ready     <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_busy  <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_bank_st     <= w_bank_nxt;
         r_rd_st       <= w_rd_nxt;
         r_widx        <= w_widx_nxt;
         r_hold        <= w_hold_nxt;
         r_wb          <= w_wb_nxt;
         r_rb          <= w_rb_nxt;
         r_s_ready     <= w_s_ready_nxt;
         r_frame_valid <= w_valid_nxt;
         r_frame_busy  <= w_busy_nxt;
         r_frame_err   <= w_err;
      end
   end

   assign bus.s_ready     = r_s_ready;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_busy  = r_frame_busy;
   assign bus.frame_err   = r_frame_err;
   assign bus.frame_real  = w_real[r_rb];
   assign bus.frame_imag  = w_imag[r_rb];

endmodule

// File: tb/tb_fft16_input_framer.sv
// Scoreboard bench for fft16_input_framer: a frame-level reference model queues
// expected frames and error pulses; a monitor checks every frame handshake.
module tb_fft16_input_framer;

   typedef struct packed {
      logic [255:0] re;
      logic [255:0] im;
   } frame_t;

   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_pass = 0;
   int   err_exp = 0;
   int   err_seen = 0;
   int   stalls = 0;
   int   ready_mode = 0;

   frame_t      exp_q[$];
   logic [15:0] cur_re[$];
   logic [15:0] cur_im[$];

   fft16_input_framer_if bus ();

   fft16_input_framer #(.HOLD_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, 256'(act), 256'(exp));
   endtask

   // reference model: a frame is any 16 accepted samples; an early s_last drops the partial frame
   task automatic model_accept(input logic [15:0] re, input logic [15:0] im, input logic last);
      frame_t f;
      cur_re.push_back(re);
      cur_im.push_back(im);
      if (cur_re.size() == 16) begin
         for (int k = 0; k < 16; k++) begin
            f.re[k*16 +: 16] = cur_re[k];
            f.im[k*16 +: 16] = cur_im[k];
         end
         exp_q.push_back(f);
         if (!last) err_exp++;
         cur_re.delete();
         cur_im.delete();
      end else if (last) begin
         err_exp++;
         cur_re.delete();
         cur_im.delete();
      end
   endtask

   // called at posedge+1; returns at posedge+1 after the sample is accepted
   task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
      int budget = 0;
      bus.s_valid = 1'b1;
      bus.s_real  = re;
      bus.s_imag  = im;
      bus.s_last  = last;
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         stalls++;
         budget++;
         if (budget > 500) break;
      end
      @(posedge clk);
      #1;
      if (budget > 500) check1("send_timeout", 1'b0, 1'b1);
      else model_accept(re, im, last);
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || bus.frame_valid || bus.frame_busy) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check1({name, "_idle_timeout"}, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // downstream ready driver
   initial begin
      bus.frame_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.frame_ready = 1'b0;
            1:       bus.frame_ready = 1'b1;
            default: bus.frame_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor: pop and compare on every frame handshake, count error pulses
   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.frame_err) begin
               check1("err_pulse_expected", (err_seen < err_exp), 1'b1);
               err_seen++;
            end
            if (bus.frame_valid && bus.frame_ready) begin
               if (exp_q.size() == 0) begin
                  check1("unexpected_frame", 1'b1, 1'b0);
               end else begin
                  f = exp_q.pop_front();
                  check("frame_real", bus.frame_real, f.re);
                  check("frame_imag", bus.frame_imag, f.im);
               end
            end
         end
      end
   end

   initial begin
      logic [255:0] snap;
      int           busy_cnt;
      int           stable;
      int           st0;
      int           vcnt;
      int           len;
      logic         lst;

      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_real  = 16'd0;
      bus.s_imag  = 16'd0;
      bus.s_last  = 1'b0;

      // reset state
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check1("rst_s_ready", bus.s_ready, 1'b0);
         check1("rst_frame_valid", bus.frame_valid, 1'b0);
         check("rst_frame_real", bus.frame_real, 256'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check1("s_ready_after_rst", bus.s_ready, 1'b1);
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;

      // single frame: latency, contents, hold window
      send(16'd256, 16'd0, 1'b0);
      send(16'd512, 16'd0, 1'b0);
      for (int j = 2; j < 16; j++) send(16'd0, 16'd0, (j == 15));
      @(negedge clk);
      check1("lat_not_early", bus.frame_valid, 1'b0);
      @(negedge clk);
      check1("lat_valid", bus.frame_valid, 1'b1);
      snap = bus.frame_real;
      check("x0_real", 256'(snap[15:0]), 256'd256);
      check("x1_real", 256'(snap[31:16]), 256'd512);
      check("x2_15_real", 256'(snap[255:32]), 256'd0);
      busy_cnt = 0;
      stable   = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.frame_busy) busy_cnt++;
         if ((bus.frame_busy || bus.frame_valid) && bus.frame_real == snap) stable++;
      end
      check("busy_cycles", 256'(busy_cnt), 256'd4);
      check("stable_cycles", 256'(stable), 256'd5);
      wait_idle("single");

      // back-to-back ramp: no stalls allowed
      st0 = stalls;
      for (int k = 0; k < 48; k++) send(16'(k), 16'(-k), (k % 16 == 15));
      check("b2b_stalls", 256'(stalls - st0), 256'd0);
      wait_idle("b2b");

      // backpressure: both banks fill, s_ready drops after sample 32
      ready_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      st0 = stalls;
      for (int k = 0; k < 32; k++) send(16'(1000 + k), 16'(k), (k % 16 == 15));
      check("bp_no_early_stall", 256'(stalls - st0), 256'd0);
      @(negedge clk);
      check1("bp_ready_low", bus.s_ready, 1'b0);
      repeat (5) @(negedge clk);
      check1("bp_ready_still_low", bus.s_ready, 1'b0);
      @(posedge clk);
      #1;
      ready_mode = 1;
      for (int k = 32; k < 48; k++) send(16'(1000 + k), 16'(k), (k % 16 == 15));
      wait_idle("bp");

      // framing errors: early s_last, clean frame, missing s_last
      for (int k = 0; k < 6; k++) send(16'(70 + k), 16'(7), (k == 5));
      for (int k = 0; k < 16; k++) send(16'(300 + k), 16'(-k), (k == 15));
      for (int k = 0; k < 16; k++) send(16'(500 + k), 16'(k * 3), 1'b0);
      wait_idle("ferr");

      // randomized frames, gaps and downstream stalls
      ready_mode = 2;
      for (int f = 0; f < 8; f++) begin
         len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) begin
                  @(posedge clk);
                  #1;
               end
            end
            lst = (j == len - 1) && !(len == 16 && $urandom_range(0, 7) == 0);
            send(16'($urandom), 16'($urandom), lst);
         end
      end
      ready_mode = 1;
      wait_idle("rand");
      check("err_count_mid", 256'(err_seen), 256'(err_exp));

      // reset during HOLD with a partial frame buffered
      for (int k = 0; k < 16; k++) send(16'(2000 + k), 16'(k), (k == 15));
      for (int k = 0; k < 3; k++) send(16'(9000 + k), 16'(k), 1'b0);
      check1("busy_before_rst", bus.frame_busy, 1'b1);
      rst_n = 1'b0;
      cur_re.delete();
      cur_im.delete();
      @(posedge clk);
      @(negedge clk);
      check1("mrst_s_ready", bus.s_ready, 1'b0);
      check1("mrst_valid", bus.frame_valid, 1'b0);
      check1("mrst_busy", bus.frame_busy, 1'b0);
      check1("mrst_err", bus.frame_err, 1'b0);
      check("mrst_real", bus.frame_real, 256'd0);
      check("mrst_imag", bus.frame_imag, 256'd0);
      rst_n = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.frame_valid) vcnt++;
      end
      check("no_stale_frame", 256'(vcnt), 256'd0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 16; k++) send(16'(3000 + k), 16'(-k), (k == 15));
      wait_idle("post_rst");

      check("err_count_final", 256'(err_seen), 256'(err_exp));
      check("frames_left", 256'(exp_q.size()), 256'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
